lbp_host: RTL

Memory-side responder for the LBP engine's gray-image read port and LBP-result write port. It holds the 128x128 gray image, serves `gray_req` reads with zero-cycle data, and captures `lbp_valid` writes into a result memory. It also checks write addresses against the image border and counts results. Result memory can be read back after `finish`. It sits opposite the LBP engine in the SoC/bench top and replaces the behavioural host memories.

---
 rtl/lbp_pkg.sv | 33 +++
 rtl/lbp_ram.sv | 55 +++++
 rtl/lbp_host.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lbp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_pkg
//  Description : Shared constants, FSM state encoding and border-test helper
//                for the LBP host memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package lbp_pkg;

    localparam int IMG_W  = 128;                    // image width/height
    localparam int AW     = 14;                     // pixel address width
    localparam int EXP_WR = (IMG_W - 2) * (IMG_W - 2);
    localparam int CW     = $clog2(IMG_W);          // column field width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Address splits into {row, col} by bit-slicing; a result written on the
    // outermost ring of pixels is a border write.
    function automatic logic is_border(input logic [AW-1:0] addr);
        logic [AW-CW-1:0] row;
        logic [CW-1:0]    col;
        row = addr[AW-1:CW];
        col = addr[CW-1:0];
        return (row == '0) || (row == (AW-CW)'(IMG_W - 1)) ||
               (col == '0) || (col == CW'(IMG_W - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lbp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_ram
//  Description : Single-write-port memory with selectable asynchronous or
//                registered read port. Array contents are never reset; only
//                the registered read output is.
//  Ports       : clk, reset      - clock, async active-high reset (read reg)
//                we/waddr/wdata  - write port
//                raddr/rdata     - read port (REG_RD=1: 1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module lbp_ram #(
    parameter int DEPTH  = 16384,
    parameter int AW     = 14,
    parameter int DW     = 8,
    parameter bit REG_RD = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    generate
        if (REG_RD) begin : g_reg_rd
            logic [DW-1:0] r_rdata;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_rdata <= '0;
                end else begin
                    r_rdata <= r_mem[raddr];
                end
            end
            assign rdata = r_rdata;
        end else begin : g_async_rd
            // Reset only matters for the registered output register.
            logic w_unused_reset;
            assign w_unused_reset = reset;
            assign rdata          = r_mem[raddr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lbp_host.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_host
//  Description : Memory-side responder for the LBP engine. Holds the gray
//                image (zero-latency reads), captures LBP results, checks
//                result addresses against the image border, counts results
//                and flags protocol violations.
//  Ports       : clk/reset                  - clock, async active-high reset
//                ld_valid/ld_addr/ld_data   - image load (IDLE/DONE only)
//                start/finish               - run control
//                gray_addr/gray_req ->
//                  gray_ready/gray_data     - engine pixel read port
//                lbp_addr/lbp_valid/lbp_data- engine result write port
//                rd_addr -> rd_data         - result readback, 1-cycle latency
//                wr_cnt/err/done/pass       - run status
//  Revision    : 1.0 - initial release
// ============================================================================
module lbp_host
    import lbp_pkg::*;
#(
    parameter int IMG_W  = lbp_pkg::IMG_W,
    parameter int AW     = lbp_pkg::AW,
    parameter int EXP_WR = lbp_pkg::EXP_WR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          start,
    input  logic [AW-1:0] gray_addr,
    input  logic          gray_req,
    output logic          gray_ready,
    output logic [7:0]    gray_data,
    input  logic [AW-1:0] lbp_addr,
    input  logic          lbp_valid,
    input  logic [7:0]    lbp_data,
    input  logic          finish,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] wr_cnt,
    output logic [1:0]    err,
    output logic          done,
    output logic          pass
);

    localparam int c_DEPTH = IMG_W * IMG_W;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_gray_ready;
    logic [AW-1:0] r_wr_cnt;
    logic [1:0]    r_err;
    logic          r_done;

    logic          w_serving;
    logic          w_enter_serve;
    logic          w_img_we;
    logic          w_res_we;
    logic          w_proto_err;
    logic          w_border_err;
    logic [7:0]    w_img_rdata;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)  w_next_state = SERVE;
            SERVE:   if (finish) w_next_state = DONE;
            DONE:    if (start)  w_next_state = SERVE;
            default:             w_next_state = IDLE;
        endcase
    end

    assign w_serving     = (r_state == SERVE);
    assign w_enter_serve = start && !w_serving;

    // Loads only outside SERVE; results only inside SERVE.
    assign w_img_we = ld_valid && !w_serving;
    assign w_res_we = lbp_valid && w_serving;

    assign w_proto_err  = (gray_req && !r_gray_ready) ||
                          (ld_valid && w_serving)     ||
                          (lbp_valid && !w_serving);
    assign w_border_err = w_res_we && is_border(lbp_addr);

    // ------------------------------------------------------------------
    // Status registers. Entering SERVE starts a clean run, so the clear
    // takes priority over anything flagged in that same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gray_ready <= 1'b0;
            r_wr_cnt     <= '0;
            r_err        <= '0;
            r_done       <= 1'b0;
        end else begin
            r_gray_ready <= (w_next_state == SERVE);
            if (w_enter_serve) begin
                r_wr_cnt <= '0;
                r_err    <= '0;
                r_done   <= 1'b0;
            end else begin
                if (w_res_we && (r_wr_cnt != '1)) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
                r_err <= r_err | {w_proto_err, w_border_err};
                if (w_serving && finish) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Memories
    // ------------------------------------------------------------------
    lbp_ram #(
        .DEPTH  (c_DEPTH),
        .AW     (AW),
        .DW     (8),
        .REG_RD (1'b0)
    ) u_img (
        .clk    (clk),
        .reset  (reset),
        .we     (w_img_we),
        .waddr  (ld_addr),
        .wdata  (ld_data),
        .raddr  (gray_addr),
        .rdata  (w_img_rdata)
    );

    lbp_ram #(
        .DEPTH  (c_DEPTH),
        .AW     (AW),
        .DW     (8),
        .REG_RD (1'b1)
    ) u_res (
        .clk    (clk),
        .reset  (reset),
        .we     (w_res_we),
        .waddr  (lbp_addr),
        .wdata  (lbp_data),
        .raddr  (rd_addr),
        .rdata  (rd_data)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gray_ready = r_gray_ready;
    assign gray_data  = (w_serving && gray_req) ? w_img_rdata : 8'h00;
    assign wr_cnt     = r_wr_cnt;
    assign err        = r_err;
    assign done       = r_done;
    assign pass       = r_done && (r_wr_cnt == AW'(EXP_WR)) && (r_err == 2'b00);

endmodule
`default_nettype wire
